// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

   // Top-level sequencing: wait for a request, stream 4 bytes, respond once.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Requester indices, also the bit positions in the arbiter request vector.
   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   localparam int BYTES_PER_WORD    = 4;
   localparam int MEM_DEPTH_DEFAULT = 4097;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; conflicts go to whoever did not win last.
// Latency: grant is combinational from req_i; history updates on accept_i.
// Backpressure: none; the winner is only remembered when the caller accepts.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o
);

   logic last_q;

   // Pick the winner; on a tie, favour the requester that lost last time.
   always_comb begin
      gnt_vld_o = |req_i;
      gnt_idx_o = GNT_IF;
      case (req_i)
         2'b01:   gnt_idx_o = GNT_IF;
         2'b10:   gnt_idx_o = GNT_D;
         2'b11:   gnt_idx_o = ~last_q;
         default: gnt_idx_o = GNT_IF;
      endcase
   end

   // Remember the last accepted winner; starting at DATA makes fetch win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= GNT_D;
      end else if (accept_i) begin
         last_q <= gnt_idx_o;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide memory between fetch and load/store, one 32-bit word as 4 LE beats.
// Latency: accept at edge T, beats T+1..T+4, response T+5 (range error: T+1).
// Backpressure: ready only in IDLE; responses are a one-cycle pulse with no stall.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int MEM_AW    = 13,
   parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   input  logic [AW-1:0]     if_req_addr,
   output logic              if_req_ready,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rsp_data,
   output logic              if_rsp_err,
   input  logic              d_req_valid,
   input  logic              d_req_we,
   input  logic [AW-1:0]     d_req_addr,
   input  logic [31:0]       d_req_wdata,
   output logic              d_req_ready,
   output logic              d_rsp_valid,
   output logic [31:0]       d_rsp_data,
   output logic              d_rsp_err,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   // Highest base address whose whole word still fits inside memory.
   localparam logic [AW-1:0] LAST_BASE = AW'(MEM_DEPTH - BYTES_PER_WORD);

   state_t            state_q, state_d;
   logic [1:0]        beat_q, beat_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [MEM_AW-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              arb_vld;
   logic              arb_idx;
   logic              accept;
   logic              sel_we;
   logic [AW-1:0]     sel_addr;
   logic [31:0]       sel_wdata;
   logic              in_xfer;
   logic              in_resp;

   // Only offer the arbiter a choice while idle, so requests are ignored mid-transfer.
   assign accept = (state_q == ST_IDLE) && arb_vld;

   rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     ({d_req_valid, if_req_valid}),
      .accept_i  (accept),
      .gnt_vld_o (arb_vld),
      .gnt_idx_o (arb_idx)
   );

   // Mux the winning requester's fields; fetch is always a read with no data.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = if_req_addr;
      sel_wdata = '0;
      if (arb_idx == GNT_D) begin
         sel_we    = d_req_we;
         sel_addr  = d_req_addr;
         sel_wdata = d_req_wdata;
      end
   end

   assign if_req_ready = accept && (arb_idx == GNT_IF);
   assign d_req_ready  = accept && (arb_idx == GNT_D);

   // Next-state: latch the request on accept, walk 4 beats, then one response cycle.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               gnt_d   = arb_idx;
               we_d    = sel_we;
               base_d  = sel_addr[MEM_AW-1:0];
               wdata_d = sel_wdata;
               rdata_d = '0;
               beat_d  = '0;
               // Out-of-range words never touch memory and answer on the next cycle.
               if (sel_addr > LAST_BASE) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_XFER;
               end
            end
         end
         ST_XFER: begin
            if (!we_q) begin
               rdata_d[8*beat_q +: 8] = mem_rdata;
            end
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and request/response registers; reset drops any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         gnt_q   <= GNT_D;
         we_q    <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign in_xfer = (state_q == ST_XFER);
   assign in_resp = (state_q == ST_RESP);

   // Memory strobes exist only during beats; everything else is held at zero.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (in_xfer) begin
         mem_addr = base_q + MEM_AW'(beat_q);
         if (we_q) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q[8*beat_q +: 8];
         end
      end
   end

   // Steer the response to the requester that owns this transfer; stores return zero data.
   always_comb begin
      if_rsp_valid = in_resp && (gnt_q == GNT_IF);
      d_rsp_valid  = in_resp && (gnt_q == GNT_D);
      if_rsp_data  = if_rsp_valid ? rdata_q : 32'h0;
      d_rsp_data   = d_rsp_valid  ? rdata_q : 32'h0;
      if_rsp_err   = if_rsp_valid && err_q;
      d_rsp_err    = d_rsp_valid  && err_q;
   end

endmodule
